// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC sample capture path into the sample RAM.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned HW_W        = 16;
    localparam int unsigned WORD_W      = 2 * HW_W;
    localparam int unsigned HW_CH_W     = 3;
    localparam int unsigned HW_SAMPLE_W = 12;

    // Half-word layout: {spare 0, channel, sample}
    function automatic logic [HW_W-1:0] pack_hw(
        input logic [HW_CH_W-1:0]     ch,
        input logic [HW_SAMPLE_W-1:0] sample
    );
        return {1'b0, ch, sample};
    endfunction

endpackage

// File: rtl/adc_pair_packer.sv
// Collects two half-words into one 32-bit word; the completed word is
// flagged combinationally in the cycle its second half is accepted.
module adc_pair_packer
    import adc_capture_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [HW_W-1:0]   hw,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    logic [HW_W-1:0] half_reg;
    logic            half_flag;

    assign word_valid_c = accept & half_flag & ~clear;
    assign word_c       = {hw, half_reg};

    // A clear drops any stored low half, including one arriving this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_reg  <= '0;
            half_flag <= 1'b0;
        end else if (clear) begin
            half_flag <= 1'b0;
        end else if (accept) begin
            if (half_flag) begin
                half_flag <= 1'b0;
            end else begin
                half_reg  <= hw;
                half_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sample_mem_writer.sv
// Packs tagged ADC samples two per word and writes them into the sample RAM
// over Avalon-MM, either one frame per start or wrapping continuously.
module adc_sample_mem_writer
    import adc_capture_pkg::*;
#(
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned CH_W     = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                continuous,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [CH_W-1:0]     sample_channel,
    output logic                sample_ready,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [3:0]          mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [31:0]         mem_writedata,
    output logic                mem_clken,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun,
    output logic [15:0]         frame_count
);

    state_t              state;
    logic                cont_mode;
    logic [ADDR_W-1:0]   wr_addr;
    logic                accept_c;
    logic                pair_clear_c;
    logic                last_c;
    logic [HW_W-1:0]     hw_c;
    logic                word_valid_c;
    logic [WORD_W-1:0]   word_c;

    assign mem_clken    = 1'b1;
    assign accept_c     = sample_valid & sample_ready;
    assign pair_clear_c = start | abort;
    assign last_c       = (wr_addr == ADDR_W'(DEPTH - 1));
    assign hw_c         = pack_hw(HW_CH_W'(sample_channel), HW_SAMPLE_W'(sample_data));

    adc_pair_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (pair_clear_c),
        .accept       (accept_c),
        .hw           (hw_c),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Control FSM; abort beats start, and both leave an already-presented write intact
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cont_mode      <= 1'b0;
            wr_addr        <= '0;
            sample_ready   <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= 4'h0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
            frame_count    <= '0;
        end else begin
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_byteenable <= 4'h0;
            frame_done     <= 1'b0;
            if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
            if (abort) begin
                state        <= IDLE;
                sample_ready <= 1'b0;
                busy         <= 1'b0;
            end else if (start) begin
                state        <= FILL;
                cont_mode    <= continuous;
                wr_addr      <= '0;
                overrun      <= 1'b0;
                frame_count  <= '0;
                sample_ready <= 1'b1;
                busy         <= 1'b1;
            end else if (state == FILL && word_valid_c) begin
                mem_write      <= 1'b1;
                mem_chipselect <= 1'b1;
                mem_byteenable <= 4'hF;
                mem_address    <= wr_addr;
                mem_writedata  <= word_c;
                if (last_c) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                    wr_addr     <= '0;
                    if (!cont_mode) begin
                        state        <= DONE;
                        sample_ready <= 1'b0;
                        busy         <= 1'b0;
                    end
                end else begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_mem_writer.sv
// Directed bench for adc_sample_mem_writer with hand-computed expectations.
module tb_adc_sample_mem_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        continuous;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [2:0]  sample_channel;
    logic        sample_ready;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_sample_mem_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .continuous     (continuous),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .sample_ready   (sample_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .frame_done     (frame_done),
        .overrun        (overrun),
        .frame_count    (frame_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] ch, input logic [11:0] s);
        sample_valid   = 1'b1;
        sample_channel = ch;
        sample_data    = s;
        tick();
    endtask

    task automatic pulse_start(input logic cont);
        start      = 1'b1;
        continuous = cont;
        tick();
        start      = 1'b0;
    endtask

    function automatic logic [2:0] tch(input int i);
        logic [31:0] v;
        v = 32'(i);
        return v[2:0];
    endfunction

    function automatic logic [11:0] tsm(input int i);
        return 12'h100 + 12'(i * 17);
    endfunction

    function automatic logic [15:0] model_hw(input int i);
        return {1'b0, tch(i), tsm(i)};
    endfunction

    initial begin
        int wcount;
        int fdcount;
        int busy_low;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        sample_valid = 1'b0; sample_data = '0; sample_channel = '0;
        tick(); tick();
        chk("rst_write",  32'(mem_write), 32'd0);
        chk("rst_clken",  32'(mem_clken), 32'd1);
        chk("rst_ready",  32'(sample_ready), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_fcount", 32'(frame_count), 32'd0);
        chk("rst_be",     32'(mem_byteenable), 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset while a half word is pending
        pulse_start(1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        send(3'd1, 12'h7AB);
        sample_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t1_rst_busy",  32'(busy), 32'd0);
        chk("t1_rst_ready", 32'(sample_ready), 32'd0);
        chk("t1_rst_data",  mem_writedata, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single word write after reset
        pulse_start(1'b0);
        chk("t2_ready", 32'(sample_ready), 32'd1);
        send(3'd1, 12'h123);
        chk("t2_nowrite", 32'(mem_write), 32'd0);
        send(3'd2, 12'h456);
        sample_valid = 1'b0;
        chk("t2_write", 32'(mem_write), 32'd1);
        chk("t2_addr",  32'(mem_address), 32'd0);
        chk("t2_data",  mem_writedata, 32'h2456_1123);
        chk("t2_be",    32'(mem_byteenable), 32'hF);
        chk("t2_cs",    32'(mem_chipselect), 32'd1);
        tick();
        chk("t2_write_end", 32'(mem_write), 32'd0);
        chk("t2_be_end",    32'(mem_byteenable), 32'd0);

        // Full single-shot frame
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(tch(i), tsm(i));
            chk($sformatf("t3_wr%0d", i), 32'(mem_write), 32'(i % 2));
            chk($sformatf("t3_fd%0d", i), 32'(frame_done), 32'(i == 7));
            if (i % 2 == 1) begin
                chk($sformatf("t3_addr%0d", i), 32'(mem_address), 32'(i / 2));
                chk($sformatf("t3_data%0d", i), mem_writedata, {model_hw(i), model_hw(i - 1)});
            end
        end
        chk("t3_ready_done", 32'(sample_ready), 32'd0);
        chk("t3_busy_done",  32'(busy), 32'd0);
        chk("t3_fcount",     32'(frame_count), 32'd1);
        chk("t3_ovr_before", 32'(overrun), 32'd0);
        send(3'd0, 12'h0);
        sample_valid = 1'b0;
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_no_extra_write", 32'(mem_write), 32'd0);

        // Continuous mode wraps twice
        pulse_start(1'b1);
        chk("t4_ovr_cleared", 32'(overrun), 32'd0);
        wcount = 0; fdcount = 0; busy_low = 0;
        for (int k = 0; k < 16; k++) begin
            send(tch(k), tsm(k));
            chk($sformatf("t4_wr%0d", k), 32'(mem_write), 32'(k % 2));
            if (mem_write) begin
                chk($sformatf("t4_addr%0d", k), 32'(mem_address), 32'(wcount % 4));
                wcount++;
            end
            if (frame_done) fdcount++;
            if (!busy) busy_low = 1;
        end
        sample_valid = 1'b0;
        chk("t4_writes",   32'(wcount), 32'd8);
        chk("t4_fd_count", 32'(fdcount), 32'd2);
        chk("t4_fcount",   32'(frame_count), 32'd2);
        chk("t4_busy_low", 32'(busy_low), 32'd0);
        tick();
        chk("t4_busy_after", 32'(busy), 32'd1);

        // Abort after three samples
        pulse_start(1'b0);
        send(3'd3, 12'h111);
        send(3'd4, 12'h222);
        chk("t5_write", 32'(mem_write), 32'd1);
        chk("t5_addr",  32'(mem_address), 32'd0);
        chk("t5_data",  mem_writedata, 32'h4222_3111);
        send(3'd5, 12'h333);
        sample_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy",  32'(busy), 32'd0);
        chk("t5_ready", 32'(sample_ready), 32'd0);
        wcount = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_write) wcount++;
        end
        chk("t5_no_writes", 32'(wcount), 32'd0);

        // Start and abort together, then restart with a pending half
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t6_idle_busy",  32'(busy), 32'd0);
        chk("t6_idle_ready", 32'(sample_ready), 32'd0);
        pulse_start(1'b0);
        send(3'd5, 12'h0AA);
        sample_valid = 1'b0;
        pulse_start(1'b0);
        chk("t6_restart_busy", 32'(busy), 32'd1);
        send(3'd6, 12'h0BB);
        chk("t6_nowrite", 32'(mem_write), 32'd0);
        send(3'd7, 12'hCCC);
        sample_valid = 1'b0;
        chk("t6_write", 32'(mem_write), 32'd1);
        chk("t6_addr",  32'(mem_address), 32'd0);
        chk("t6_data",  mem_writedata, 32'h7CCC_60BB);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t6_fill_abort_busy", 32'(busy), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
